// File: rtl/enc_binder_array.sv
// enc_binder_array: binds NUM_CH level hypervectors by rotating each channel
// by its own fixed amount S(i) = (SHIFT_BASE + i*SHIFT_STEP) mod HV_DIM.
// Channels share LANES rotators over BEATS = ceil(NUM_CH/LANES) cycles.
// Unbind mode uses the inverse (right) rotation so unbind(bind(x)) == x.
// Inputs are captured when a job starts, so upstream may change them while
// the job runs. shifted_hv is meaningful only while out_valid is high.
module enc_binder_array #(
    parameter int HV_DIM     = 1024,
    parameter int NUM_CH     = 10,
    parameter int LANES      = 2,
    parameter int SHIFT_BASE = 0,
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_encoding,
    input  logic              unbind,
    input  logic [HV_DIM-1:0] level_hv   [0:NUM_CH-1],
    output logic [HV_DIM-1:0] shifted_hv [0:NUM_CH-1],
    output logic              busy,
    output logic              done,
    output logic              out_valid
);

    localparam int BEATS  = (NUM_CH + LANES - 1) / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic [HV_DIM-1:0] cap_hv [0:NUM_CH-1];
    logic              cap_unbind;

    logic [HV_DIM-1:0] lane_in  [0:LANES-1];
    int                lane_sh  [0:LANES-1];
    logic [HV_DIM-1:0] lane_out [0:LANES-1];

    // Rotation amount of a channel; folded to a constant wherever ch is constant.
    function automatic int shift_of(input int ch);
        int s;
        s = (SHIFT_BASE + ch * SHIFT_STEP) % HV_DIM;
        if (s < 0) begin
            s = s + HV_DIM;
        end
        return s;
    endfunction

    // Circular rotation by s in [0, HV_DIM-1]; a shift by HV_DIM yields zero,
    // which makes s = 0 a clean passthrough.
    function automatic logic [HV_DIM-1:0] rotate(input logic [HV_DIM-1:0] x,
                                                 input int s,
                                                 input logic right);
        if (right) begin
            return (x >> s) | (x << (HV_DIM - s));
        end
        return (x << s) | (x >> (HV_DIM - s));
    endfunction

    // Lane steering: route the channels of the current beat into the shared
    // rotators together with their shift amounts; lanes past NUM_CH idle at 0.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = '0;
            lane_sh[l] = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (c == int'(beat) * LANES + l) begin
                    lane_in[l] = cap_hv[c];
                    lane_sh[l] = shift_of(c);
                end
            end
            lane_out[l] = rotate(lane_in[l], lane_sh[l], cap_unbind);
        end
    end

    // Job sequencer: capture on start, write one beat of channels per cycle,
    // then pulse done and return to IDLE; reset aborts and clears everything.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state      <= IDLE;
            beat       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            cap_unbind <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                cap_hv[c]     <= '0;
                shifted_hv[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_encoding) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            cap_hv[c] <= level_hv[c];
                        end
                        cap_unbind <= unbind;
                        out_valid  <= 1'b0;
                        beat       <= '0;
                        busy       <= 1'b1;
                        state      <= BIND;
                    end
                end
                BIND: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (c == int'(beat) * LANES + l) begin
                                shifted_hv[c] <= lane_out[l];
                            end
                        end
                    end
                    if (beat == BEAT_W'(BEATS - 1)) begin
                        done      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_binder_array.sv
// tb_enc_binder_array: scoreboard bench for enc_binder_array.
// Four instances share the clock and reset: the main one (LANES=2) and three
// parameter variants (LANES=5, LANES=1, and a zero-rotation configuration).
// Every accepted job pushes its expected channels and done cycle into a
// per-instance queue; a monitor per instance pops and compares on done.
module tb_enc_binder_array;

    localparam int W = 16;
    localparam int N = 5;

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef struct packed {
        vec_t hv;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         nrst;
    logic         start_main;
    logic         start_sweep;
    logic         unbind;
    logic [W-1:0] level_hv [0:N-1];

    logic [W-1:0] hv_main [0:N-1];
    logic [W-1:0] hv_l5   [0:N-1];
    logic [W-1:0] hv_l1   [0:N-1];
    logic [W-1:0] hv_z    [0:N-1];
    logic busy_main, done_main, ov_main;
    logic busy_l5, done_l5, ov_l5;
    logic busy_l1, done_l1, ov_l1;
    logic busy_z, done_z, ov_z;

    vec_t out_main, out_l5, out_l1, out_z;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    exp_t q_main[$];
    exp_t q_l5[$];
    exp_t q_l1[$];
    exp_t q_z[$];

    enc_binder_array #(.HV_DIM(W), .NUM_CH(N), .LANES(2), .SHIFT_BASE(3), .SHIFT_STEP(7)) u_main (
        .clk(clk), .nrst(nrst), .start_encoding(start_main), .unbind(unbind),
        .level_hv(level_hv), .shifted_hv(hv_main),
        .busy(busy_main), .done(done_main), .out_valid(ov_main));

    enc_binder_array #(.HV_DIM(W), .NUM_CH(N), .LANES(5), .SHIFT_BASE(3), .SHIFT_STEP(7)) u_l5 (
        .clk(clk), .nrst(nrst), .start_encoding(start_sweep), .unbind(unbind),
        .level_hv(level_hv), .shifted_hv(hv_l5),
        .busy(busy_l5), .done(done_l5), .out_valid(ov_l5));

    enc_binder_array #(.HV_DIM(W), .NUM_CH(N), .LANES(1), .SHIFT_BASE(3), .SHIFT_STEP(7)) u_l1 (
        .clk(clk), .nrst(nrst), .start_encoding(start_sweep), .unbind(unbind),
        .level_hv(level_hv), .shifted_hv(hv_l1),
        .busy(busy_l1), .done(done_l1), .out_valid(ov_l1));

    enc_binder_array #(.HV_DIM(W), .NUM_CH(N), .LANES(2), .SHIFT_BASE(16), .SHIFT_STEP(0)) u_z (
        .clk(clk), .nrst(nrst), .start_encoding(start_sweep), .unbind(unbind),
        .level_hv(level_hv), .shifted_hv(hv_z),
        .busy(busy_z), .done(done_z), .out_valid(ov_z));

    // Cycle counter; read at negedges it names the cycle being sampled.
    always @(posedge clk) cyc <= cyc + 1;

    // Flatten the unpacked DUT outputs so they can be compared as vectors.
    always_comb begin
        out_main = '0;
        out_l5   = '0;
        out_l1   = '0;
        out_z    = '0;
        for (int c = 0; c < N; c++) begin
            out_main[c] = hv_main[c];
            out_l5[c]   = hv_l5[c];
            out_l1[c]   = hv_l1[c];
            out_z[c]    = hv_z[c];
        end
    end

    // Shift amounts of the main configuration, worked out by hand: 3,10,1,8,15.
    function automatic int s_main(input int c);
        case (c)
            0:       return 3;
            1:       return 10;
            2:       return 1;
            3:       return 8;
            default: return 15;
        endcase
    endfunction

    // Bit-by-bit rotation straight from the index definition.
    function automatic logic [W-1:0] rot_model(input logic [W-1:0] x, input int s, input logic right);
        logic [W-1:0] r;
        for (int j = 0; j < W; j++) begin
            r[j] = right ? x[(j + s) % W] : x[(j - s + W) % W];
        end
        return r;
    endfunction

    function automatic vec_t bind_model(input vec_t x, input logic right, input logic zero_shift);
        vec_t r;
        for (int c = 0; c < N; c++) begin
            r[c] = rot_model(x[c], zero_shift ? 0 : s_main(c), right);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic checkJob(input string name, input vec_t act, input logic ov, input exp_t e);
        for (int c = 0; c < N; c++) begin
            checkOutput($sformatf("%s ch%0d", name, c), 32'(act[c]), 32'(e.hv[c]));
        end
        checkOutput({name, " out_valid at done"}, 32'(ov), 32'd1);
        checkOutput({name, " done cycle"}, cyc, e.due);
    endtask

    // Drive one request cycle (called just after a negedge), then drop start.
    task automatic applyStimulus(input logic to_main, input logic to_sweep, input logic u, input vec_t hv);
        start_main  = to_main;
        start_sweep = to_sweep;
        unbind      = u;
        for (int c = 0; c < N; c++) begin
            level_hv[c] = hv[c];
        end
        @(negedge clk);
        start_main  = 1'b0;
        start_sweep = 1'b0;
    endtask

    // Wait for the main done pulse with a bounded budget, then step into IDLE.
    task automatic waitMainDone();
        int k;
        k = 0;
        while (done_main !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            checkOutput("main done timeout", 32'(done_main), 32'd1);
        end
        @(negedge clk);
    endtask

    // Main-instance monitor: each done pulse must match the oldest expectation.
    always @(negedge clk) begin : mon_main
        exp_t e;
        if (done_main === 1'b1) begin
            if (q_main.size() == 0) begin
                checkOutput("main spurious done", 32'(done_main), 32'd0);
            end else begin
                e = q_main.pop_front();
                checkJob("main", out_main, ov_main, e);
            end
        end
    end

    // LANES=5 monitor.
    always @(negedge clk) begin : mon_l5
        exp_t e;
        if (done_l5 === 1'b1) begin
            if (q_l5.size() == 0) begin
                checkOutput("l5 spurious done", 32'(done_l5), 32'd0);
            end else begin
                e = q_l5.pop_front();
                checkJob("l5", out_l5, ov_l5, e);
            end
        end
    end

    // LANES=1 monitor.
    always @(negedge clk) begin : mon_l1
        exp_t e;
        if (done_l1 === 1'b1) begin
            if (q_l1.size() == 0) begin
                checkOutput("l1 spurious done", 32'(done_l1), 32'd0);
            end else begin
                e = q_l1.pop_front();
                checkJob("l1", out_l1, ov_l1, e);
            end
        end
    end

    // Zero-rotation monitor.
    always @(negedge clk) begin : mon_z
        exp_t e;
        if (done_z === 1'b1) begin
            if (q_z.size() == 0) begin
                checkOutput("zero spurious done", 32'(done_z), 32'd0);
            end else begin
                e = q_z.pop_front();
                checkJob("zero", out_z, ov_z, e);
            end
        end
    end

    // Hard stop in case something wedges the stimulus.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        vec_t ones, s1, allf, x, b, y, sw;
        int   t0;

        for (int c = 0; c < N; c++) begin
            ones[c] = 16'h0001;
            allf[c] = 16'hFFFF;
        end
        s1[0] = 16'h0008;
        s1[1] = 16'h0400;
        s1[2] = 16'h0002;
        s1[3] = 16'h0100;
        s1[4] = 16'h8000;

        nrst        = 1'b1;
        start_main  = 1'b0;
        start_sweep = 1'b0;
        unbind      = 1'b0;
        for (int c = 0; c < N; c++) level_hv[c] = 16'h5A5A;

        // Reset state, with start asserted to show reset wins.
        start_main = 1'b1;
        repeat (3) @(negedge clk);
        start_main = 1'b0;
        checkOutput("reset busy", 32'(busy_main), 32'd0);
        checkOutput("reset done", 32'(done_main), 32'd0);
        checkOutput("reset out_valid", 32'(ov_main), 32'd0);
        checkOutput("reset shifted_hv", 32'(out_main[N-1:0] != '0), 32'd0);
        nrst = 1'b0;
        @(negedge clk);

        // Scenario 1: bind of single-bit vectors, busy/out_valid timing.
        $display("[TB] scenario 1: bind");
        t0 = cyc;
        q_main.push_back('{hv: s1, due: t0 + 4});
        applyStimulus(1'b1, 1'b0, 1'b0, ones);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            checkOutput($sformatf("s1 busy t+%0d", k), 32'(busy_main), 32'(k <= 4));
            checkOutput($sformatf("s1 out_valid t+%0d", k), 32'(ov_main), 32'(k >= 4));
        end

        // Scenario 2: unbind of scenario-1 results, then random round trips.
        $display("[TB] scenario 2: unbind round trip");
        q_main.push_back('{hv: ones, due: cyc + 4});
        applyStimulus(1'b1, 1'b0, 1'b1, s1);
        waitMainDone();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < N; c++) x[c] = 16'($urandom);
            b = bind_model(x, 1'b0, 1'b0);
            q_main.push_back('{hv: b, due: cyc + 4});
            applyStimulus(1'b1, 1'b0, 1'b0, x);
            waitMainDone();
            y = out_main;
            for (int c = 0; c < N; c++) begin
                checkOutput($sformatf("popcount r%0d ch%0d", r, c), $countones(y[c]), $countones(x[c]));
            end
            q_main.push_back('{hv: x, due: cyc + 4});
            applyStimulus(1'b1, 1'b0, 1'b1, y);
            waitMainDone();
        end

        // Scenario 3: inputs change and starts arrive while busy (also in DONE).
        $display("[TB] scenario 3: start ignored while busy");
        t0 = cyc;
        q_main.push_back('{hv: s1, due: t0 + 4});
        applyStimulus(1'b1, 1'b0, 1'b0, ones);
        unbind = 1'b1;
        for (int c = 0; c < N; c++) level_hv[c] = 16'hFFFF;
        @(negedge clk);
        start_main = 1'b1;
        @(negedge clk);
        start_main = 1'b0;
        checkOutput("s3 busy t+3", 32'(busy_main), 32'd1);
        @(negedge clk);
        start_main = 1'b1;
        @(negedge clk);
        unbind = 1'b0;
        q_main.push_back('{hv: allf, due: cyc + 4});
        @(negedge clk);
        start_main = 1'b0;
        waitMainDone();

        // Scenario 4: reset in the middle of a job.
        $display("[TB] scenario 4: reset mid-job");
        applyStimulus(1'b1, 1'b0, 1'b0, ones);
        nrst = 1'b1;
        @(negedge clk);
        nrst = 1'b0;
        checkOutput("s4 busy after reset", 32'(busy_main), 32'd0);
        checkOutput("s4 done after reset", 32'(done_main), 32'd0);
        checkOutput("s4 out_valid after reset", 32'(ov_main), 32'd0);
        for (int c = 0; c < N; c++) begin
            checkOutput($sformatf("s4 ch%0d after reset", c), 32'(out_main[c]), 32'd0);
        end
        repeat (6) @(negedge clk);
        q_main.push_back('{hv: s1, due: cyc + 4});
        applyStimulus(1'b1, 1'b0, 1'b0, ones);
        waitMainDone();

        // Scenario 5: parameter variants, bind then unbind.
        $display("[TB] scenario 5: parameter sweep");
        sw[0] = 16'h1234;
        sw[1] = 16'hA5A5;
        sw[2] = 16'h8001;
        sw[3] = 16'h00F0;
        sw[4] = 16'hFFFE;
        for (int u = 0; u < 2; u++) begin
            b = bind_model(sw, u[0], 1'b0);
            q_l5.push_back('{hv: b, due: cyc + 2});
            q_l1.push_back('{hv: b, due: cyc + 6});
            q_z.push_back('{hv: sw, due: cyc + 4});
            applyStimulus(1'b0, 1'b1, u[0], sw);
            repeat (8) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        checkOutput("main jobs outstanding", q_main.size(), 32'd0);
        checkOutput("l5 jobs outstanding", q_l5.size(), 32'd0);
        checkOutput("l1 jobs outstanding", q_l1.size(), 32'd0);
        checkOutput("zero jobs outstanding", q_z.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enc_binder_array.md
Name: enc_binder_array

Overview:
- Parametrised successor to the fixed 10-channel encoder binder packs: one module binds NUM_CH level hypervectors by per-channel circular rotation.
- Channels are time-multiplexed over LANES rotators. Area versus latency is therefore a parameter choice.
- Adds a runtime unbind mode (inverse rotation), input capture at start, and a busy/done handshake.
- Sits between the level-HV lookup and the bundling stage of the sparse HDC encoder.

Parameters:
- HV_DIM, 1024, hypervector width in bits.
- NUM_CH, 10, number of channels bound per encoding.
- LANES, 2, channels rotated per cycle; 1 <= LANES <= NUM_CH.
- SHIFT_BASE, 0, rotation amount of channel 0.
- SHIFT_STEP, 1, rotation increment per channel.
- Derived: BEATS = ceil(NUM_CH/LANES); S(i) = (SHIFT_BASE + i*SHIFT_STEP) mod HV_DIM, computed at elaboration with 32-bit integer arithmetic.

Ports:
- clk  input  1  clock, rising edge.
- nrst  input  1  reset, synchronous, active-high (1 = reset on next rising edge).
- start_encoding  input  1  single-cycle request; sampled only in IDLE.
- unbind  input  1  mode, captured with start: 0 = rotate left by S(i), 1 = rotate right by S(i).
- level_hv  input  HV_DIM x [0:NUM_CH-1]  channel hypervectors, captured with start.
- shifted_hv  output  HV_DIM x [0:NUM_CH-1]  bound hypervectors, registered.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle pulse when every channel of the current job is written.
- out_valid  output  1  level signal; high once shifted_hv holds a complete result, cleared by the next accepted start.

Behaviour:
Reset:
- nrst = 1 at a rising edge forces state IDLE and beat counter 0.
- It clears all shifted_hv to 0, busy = 0, done = 0, out_valid = 0, and the captured inputs to 0.
- Reset overrides every other input in the same cycle.

State machine (IDLE, BIND, DONE):
- IDLE: when start_encoding = 1, capture level_hv[] and unbind, clear out_valid, set beat = 0, go to BIND. Otherwise hold all outputs.
- BIND: each cycle rotates captured channels beat*LANES .. beat*LANES+LANES-1 and writes them into shifted_hv. Indices >= NUM_CH in the final partial beat are ignored. After beat BEATS-1, go to DONE; otherwise beat++.
- DONE: done = 1 for exactly this cycle, out_valid = 1 from this cycle onward, then return to IDLE.

Rotation:
- Left: out[j] = in[(j - S) mod HV_DIM].
- Right: out[j] = in[(j + S) mod HV_DIM].
- S = 0 is passthrough. Rotation never drops or inverts bits, so popcount(out) = popcount(in).

Timing:
- Start accepted at cycle t (registered in IDLE).
- Channel writes complete at edges t+1 .. t+BEATS.
- done is high in cycle t+BEATS+1.
- busy is high in cycles t+1 .. t+BEATS+1.
- Total latency is BEATS+1 cycles after the accept.
- LANES = NUM_CH gives a 2-cycle latency.

Boundary conditions:
- start_encoding while busy, including in DONE, is ignored: no queueing, no error flag, the job in flight is unaffected.
- Back-to-back jobs: start may be asserted in the cycle after done and is accepted, since state is IDLE.
- level_hv and unbind changes after the accept cycle do not affect the running job.
- shifted_hv channels from the previous job are overwritten beat by beat during BIND. Outputs are consistent only while out_valid = 1.
- Reset mid-BIND aborts the job: no done pulse, all outputs zero.
- Combined channel shift amounts beyond HV_DIM wrap via the mod rule. SHIFT_STEP = 0 gives every channel the same rotation.

Test Plan:
Configuration for all scenarios: HV_DIM=16, NUM_CH=5, LANES=2, SHIFT_BASE=3, SHIFT_STEP=7, giving S = 3, 10, 1, 8, 15 and BEATS = 3.
1. Bind: all level_hv = 16'h0001, unbind=0, start at t -> done high only at t+4, busy high t+1..t+4. shifted_hv = 0x0008, 0x0400, 0x0002, 0x0100, 0x8000; out_valid=1 from t+4.
2. Unbind round trip: feed the scenario-1 outputs with unbind=1 -> all shifted_hv = 0x0001. Repeat with random vectors: unbind(bind(x)) == x and popcount preserved.
3. Start ignored while busy, plus input capture: second start at t+2 and level_hv changed to 0xFFFF at t+1 -> no extra done, results equal scenario 1. Next start one cycle after done is accepted, with the next done 4 cycles later.
4. Reset mid-op: nrst=1 at t+2 -> next cycle state IDLE, shifted_hv all 0, busy=0, done never pulses. A fresh start then completes normally.
5. Parameter sweep: LANES=5 -> done at t+2. LANES=1 -> done at t+6. HV_DIM=16 with SHIFT_BASE=16, SHIFT_STEP=0 -> outputs equal inputs.
